// File: rtl/instr_seq_pkg.sv
// -----------------------------------------------------------------------------
// instr_seq_pkg
// Shared types and helpers for the instruction sequencer.
//   - seq_state_e  : sequencer FSM states
//   - *_DEF        : default NUM_REQ / DATA_W / LEN_W values
//   - len_to_steps : burst-length field to step count (field 0 = 2^len_w steps)
// -----------------------------------------------------------------------------
package instr_seq_pkg;

  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned LEN_W_DEF   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SETTLE = 2'd2,
    REPORT = 2'd3
  } seq_state_e;

  // A zero length field encodes the largest burst, so every job does at
  // least one step and the full 2^len_w range is reachable.
  function automatic int unsigned len_to_steps(input int unsigned len_field,
                                               input int unsigned len_w);
    return (len_field == 0) ? (32'd1 << len_w) : len_field;
  endfunction

endpackage : instr_seq_pkg

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick. Searches req_i upward starting at ptr_i,
// wrapping modulo NUM_REQ; the first set bit wins. The pointer register is
// owned by the caller.
// Ports:
//   req_i    in  NUM_REQ  request vector
//   ptr_i    in  IDX_W    search start index (must be < NUM_REQ)
//   grant_o  out NUM_REQ  one-hot grant (all zero when no request)
//   winner_o out IDX_W    index of the granted bit (0 when no request)
//   any_o    out 1        at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   winner_o,
  output logic               any_o
);

  logic        found;
  int unsigned idx;

  // NOTE: every variable written here gets a default before any branch, so
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    grant_o  = '0;
    winner_o = '0;
    found    = 1'b0;
    idx      = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(ptr_i) + i) % NUM_REQ;
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        winner_o     = IDX_W'(idx);
      end
    end
  end

  assign any_o = |req_i;

endmodule : rr_arbiter

// File: rtl/instr_seq_ctrl.sv
// -----------------------------------------------------------------------------
// instr_seq_ctrl
// Multi-requester sequencer for the 8-bit increment-or-reload datapath.
// Grants one requester at a time (round robin), drives instr_valid/data to
// the datapath for the programmed number of steps, waits one settle cycle,
// then returns the datapath state to the requester with a one-cycle pulse.
// Ports:
//   clk            in  1               rising-edge clock
//   reset_n        in  1               synchronous active-low reset
//   req_valid_i    in  NUM_REQ         per-requester job request
//   req_ready_o    out NUM_REQ         per-requester accept (at most one set)
//   req_data_i     in  NUM_REQ*DATA_W  reload value, requester k at [k*DATA_W +: DATA_W]
//   req_len_i      in  NUM_REQ*LEN_W   step count field, requester k at [k*LEN_W +: LEN_W]
//   instr_valid_o  out 1               datapath instr_valid
//   data_out_o     out DATA_W          datapath data_in
//   state_in_i     in  DATA_W          datapath state_out
//   done_valid_o   out 1               completion pulse
//   done_id_o      out IDX_W           requester of the completed job
//   done_state_o   out DATA_W          datapath state after the job
//   busy_o         out 1               FSM not in IDLE
// -----------------------------------------------------------------------------
module instr_seq_ctrl
  import instr_seq_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned LEN_W   = LEN_W_DEF,
  localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
  input  logic [NUM_REQ*LEN_W-1:0]    req_len_i,
  output logic                        instr_valid_o,
  output logic [DATA_W-1:0]           data_out_o,
  input  logic [DATA_W-1:0]           state_in_i,
  output logic                        done_valid_o,
  output logic [IDX_W-1:0]            done_id_o,
  output logic [DATA_W-1:0]           done_state_o,
  output logic                        busy_o
);

  // One extra bit so the counter can hold 2^LEN_W for a zero length field.
  localparam int unsigned CNT_W = LEN_W + 1;

  seq_state_e         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   id_q, id_d;
  logic [DATA_W-1:0]  done_state_q, done_state_d;

  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   winner;
  logic               any_req;
  logic [DATA_W-1:0]  win_data;
  logic [LEN_W-1:0]   win_len;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req_i    (req_valid_i),
    .ptr_i    (ptr_q),
    .grant_o  (grant),
    .winner_o (winner),
    .any_o    (any_req)
  );

  assign win_data = req_data_i[winner*DATA_W +: DATA_W];
  assign win_len  = req_len_i[winner*LEN_W +: LEN_W];

  // Next-state and datapath-side register updates.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    data_d       = data_q;
    cnt_d        = cnt_q;
    id_d         = id_q;
    done_state_d = done_state_q;

    unique case (state_q)
      IDLE: begin
        // The grant only ever lands on a valid bit, so any pending request
        // means the winner's valid/ready handshake completes this edge.
        if (any_req) begin
          data_d  = win_data;
          id_d    = winner;
          cnt_d   = CNT_W'(len_to_steps(32'(win_len), LEN_W));
          ptr_d   = (32'(winner) == NUM_REQ - 1) ? '0 : winner + IDX_W'(1);
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        // The last step was clocked into the datapath at the end of the
        // final ISSUE cycle, so its output is final here.
        done_state_d = state_in_i;
        state_d      = REPORT;
      end
      REPORT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      data_q       <= '0;
      cnt_q        <= '0;
      id_q         <= '0;
      done_state_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      data_q       <= data_d;
      cnt_q        <= cnt_d;
      id_q         <= id_d;
      done_state_q <= done_state_d;
    end
  end

  // Ready is masked by reset_n so no requester sees an accept while reset is
  // being applied, even though the state only clears on the next edge.
  assign req_ready_o   = ((state_q == IDLE) && reset_n) ? grant : '0;
  assign instr_valid_o = (state_q == ISSUE);
  assign data_out_o    = data_q;
  assign done_valid_o  = (state_q == REPORT);
  assign done_id_o     = id_q;
  assign done_state_o  = done_state_q;
  assign busy_o        = (state_q != IDLE);

endmodule : instr_seq_ctrl

// File: tb/tb_instr_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_instr_seq_ctrl
// Self-checking bench: instr_seq_ctrl driving a behavioural model of the
// increment-or-reload datapath. Accepted jobs are pushed to a scoreboard with
// their expected final state; completions pop and compare.
// -----------------------------------------------------------------------------
module tb_instr_seq_ctrl;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int LW = 4;
  localparam int IW = 2;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [NR-1:0]      req_valid;
  logic [NR-1:0]      req_ready;
  logic [NR*DW-1:0]   req_data;
  logic [NR*LW-1:0]   req_len;
  logic               instr_valid;
  logic [DW-1:0]      data_out;
  logic [DW-1:0]      dp_q;
  logic               done_valid;
  logic [IW-1:0]      done_id;
  logic [DW-1:0]      done_state;
  logic               busy;

  logic               dp_load;
  logic [DW-1:0]      dp_preload;

  always #5 clk = ~clk;

  instr_seq_ctrl #(
    .NUM_REQ (NR),
    .DATA_W  (DW),
    .LEN_W   (LW)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_data_i    (req_data),
    .req_len_i     (req_len),
    .instr_valid_o (instr_valid),
    .data_out_o    (data_out),
    .state_in_i    (dp_q),
    .done_valid_o  (done_valid),
    .done_id_o     (done_id),
    .done_state_o  (done_state),
    .busy_o        (busy)
  );

  // Datapath model: on each valid instruction, reload from data_in when the
  // state is 0xFF, otherwise increment.
  always_ff @(posedge clk) begin
    if (!reset_n)         dp_q <= '0;
    else if (dp_load)     dp_q <= dp_preload;
    else if (instr_valid) dp_q <= (dp_q == 8'hFF) ? data_out : dp_q + 8'd1;
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] dp_step(input logic [DW-1:0] s, input logic [DW-1:0] d);
    return (s == 8'hFF) ? d : s + 8'd1;
  endfunction

  function automatic int rr_pick(input int ptr, input logic [NR-1:0] v);
    int j;
    for (int i = 0; i < NR; i++) begin
      j = (ptr + i) % NR;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard / monitor
  // ---------------------------------------------------------------------------
  typedef struct {
    int            id;
    logic [DW-1:0] data;
    int            steps;
    logic [DW-1:0] state;
  } job_t;

  job_t          sb_q[$];
  int            grant_log[$];
  int            busy_left  = 0;  // cycles of the current job still expected busy
  int            model_ptr  = 0;
  logic [DW-1:0] model_dp   = '0;
  int            ivalid_run = 0;
  int            last_ivalid = 0;
  logic [DW-1:0] last_done_state = '0;
  int            last_done_id = 0;
  int            done_cnt[NR];

  task automatic monitor_cycle();
    logic          exp_busy;
    logic [NR-1:0] exp_ready;
    int            w;
    int            lf;
    job_t          j;
    if (!reset_n) begin
      sb_q.delete();
      busy_left  = 0;
      model_ptr  = 0;
      model_dp   = '0;
      ivalid_run = 0;
      check("ready_in_reset", 32'(req_ready), 32'(0));
      return;
    end
    exp_busy = (busy_left != 0);
    check("busy", 32'(busy), 32'(exp_busy));
    check("instr_valid", 32'(instr_valid), 32'(busy_left >= 3));
    check("done_valid", 32'(done_valid), 32'(busy_left == 1));
    if (instr_valid) ivalid_run++;
    if (busy_left >= 3 && sb_q.size() > 0)
      check("data_out", 32'(data_out), 32'(sb_q[0].data));
    if (done_valid) begin
      if (sb_q.size() == 0) begin
        check("done_with_empty_sb", 32'(sb_q.size()), 32'(1));
      end else begin
        j = sb_q.pop_front();
        check("done_id", 32'(done_id), 32'(j.id));
        check("done_state", 32'(done_state), 32'(j.state));
        check("ivalid_len", 32'(ivalid_run), 32'(j.steps));
        last_done_state = done_state;
        last_done_id    = int'(done_id);
        last_ivalid     = ivalid_run;
        done_cnt[j.id]++;
      end
    end
    exp_ready = '0;
    w = -1;
    if (!exp_busy) begin
      w = rr_pick(model_ptr, req_valid);
      if (w >= 0) exp_ready[w] = 1'b1;
    end
    check("ready", 32'(req_ready), 32'(exp_ready));
    if (busy_left > 0) busy_left--;
    // Accept happens at the coming posedge when valid and ready coincide.
    if (!exp_busy && w >= 0 && (req_valid & req_ready) != '0) begin
      lf      = int'(req_len[w*LW +: LW]);
      j.id    = w;
      j.data  = req_data[w*DW +: DW];
      j.steps = (lf == 0) ? (1 << LW) : lf;
      j.state = model_dp;
      for (int s = 0; s < j.steps; s++) j.state = dp_step(j.state, j.data);
      model_dp   = j.state;
      model_ptr  = (w + 1) % NR;
      busy_left  = j.steps + 2;
      ivalid_run = 0;
      sb_q.push_back(j);
      grant_log.push_back(w);
    end
  endtask

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      monitor_cycle();
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic set_req(input int k, input logic [DW-1:0] d, input logic [LW-1:0] l);
    req_data[k*DW +: DW] = d;
    req_len[k*LW +: LW]  = l;
  endtask

  task automatic do_job(input int k, input logic [LW-1:0] l, input logic [DW-1:0] d);
    logic got;
    got = 1'b0;
    set_req(k, d, l);
    req_valid[k] = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready[k]) begin
        got = 1'b1;
        break;
      end
    end
    check("accept_wait", 32'(got), 32'(1));
    @(posedge clk);
    #1 req_valid[k] = 1'b0;
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (busy_left == 0 && sb_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_wait", 32'(ok), 32'(1));
  endtask

  task automatic preload(input logic [DW-1:0] v);
    @(posedge clk);
    #1;
    dp_preload = v;
    dp_load    = 1'b1;
    @(posedge clk);
    #1 dp_load = 1'b0;
    model_dp = v;
  endtask

  task automatic idle_reset();
    @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic got;
    reset_n    = 1'b0;
    req_valid  = '1;   // ready must stay low while reset is applied
    req_data   = '0;
    req_len    = '0;
    dp_load    = 1'b0;
    dp_preload = '0;
    foreach (done_cnt[i]) done_cnt[i] = 0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_instr_valid", 32'(instr_valid), 32'(0));
    check("rst_data_out", 32'(data_out), 32'(0));
    check("rst_done_valid", 32'(done_valid), 32'(0));
    check("rst_done_id", 32'(done_id), 32'(0));
    check("rst_done_state", 32'(done_state), 32'(0));
    @(posedge clk);
    #1;
    reset_n   = 1'b1;
    req_valid = '0;

    // Requester 0, len 3, from reset datapath state 0
    do_job(0, 4'd3, 8'h55);
    wait_idle();
    check("t1_state", 32'(last_done_state), 32'h03);
    check("t1_id", 32'(last_done_id), 32'(0));
    check("t1_ivalid", 32'(last_ivalid), 32'(3));

    // Reload across 0xFF: FD -> FE, FF, A0, A1
    preload(8'hFD);
    do_job(1, 4'd4, 8'hA0);
    wait_idle();
    check("t2_state", 32'(last_done_state), 32'hA1);
    check("t2_id", 32'(last_done_id), 32'(1));

    // All requesters continuously valid from pointer 0
    idle_reset();
    foreach (done_cnt[i]) done_cnt[i] = 0;
    grant_log.delete();
    for (int k = 0; k < NR; k++) set_req(k, DW'(8'h11 * (k + 1)), LW'((k % 3) + 1));
    req_valid = '1;
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #1;
      if (grant_log.size() >= 5) begin
        got = 1'b1;
        break;
      end
    end
    check("rr_five_grants", 32'(got), 32'(1));
    @(posedge clk);
    #1 req_valid = '0;
    wait_idle();
    if (grant_log.size() >= 5) begin
      check("rr_g0", 32'(grant_log[0]), 32'(0));
      check("rr_g1", 32'(grant_log[1]), 32'(1));
      check("rr_g2", 32'(grant_log[2]), 32'(2));
      check("rr_g3", 32'(grant_log[3]), 32'(3));
      check("rr_g4", 32'(grant_log[4]), 32'(0));
    end
    check("rr_done0", 32'(done_cnt[0]), 32'(2));
    check("rr_done1", 32'(done_cnt[1]), 32'(1));
    check("rr_done2", 32'(done_cnt[2]), 32'(1));
    check("rr_done3", 32'(done_cnt[3]), 32'(1));

    // Zero length field = 16 steps, no reload crossing
    preload(8'h10);
    do_job(2, 4'd0, 8'h77);
    wait_idle();
    check("len0_state", 32'(last_done_state), 32'h20);
    check("len0_ivalid", 32'(last_ivalid), 32'(16));
    check("len0_id", 32'(last_done_id), 32'(2));

    // Reset during ISSUE: job from requester 1 is dropped, pointer returns to 0
    foreach (done_cnt[i]) done_cnt[i] = 0;
    do_job(1, 4'd8, 8'h33);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    set_req(0, 8'h44, 4'd2);
    set_req(2, 8'h66, 4'd1);
    req_valid = 4'b0101;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 32'(0));
    check("mid_rst_instr_valid", 32'(instr_valid), 32'(0));
    check("mid_rst_done_valid", 32'(done_valid), 32'(0));
    check("mid_rst_ready", 32'(req_ready), 32'(4'b0001));
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready[2]) begin
        got = 1'b1;
        break;
      end
    end
    check("mid_rst_second_accept", 32'(got), 32'(1));
    @(posedge clk);
    #1 req_valid[2] = 1'b0;
    wait_idle();
    check("mid_rst_done1", 32'(done_cnt[1]), 32'(0));
    check("mid_rst_done0", 32'(done_cnt[0]), 32'(1));
    check("mid_rst_done2", 32'(done_cnt[2]), 32'(1));
    check("mid_rst_state", 32'(last_done_state), 32'h03);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global guard so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL global_timeout got=%0t exp=<200000", $time);
    $fatal(1, "timeout");
  end

endmodule : tb_instr_seq_ctrl
